riscv_ex_pipe_stg: RTL
======================

Name: riscv_ex_pipe_stg

Overview:
Parametrised successor to the single-stage execute pipe. It is a STAGES-deep elastic integer execute pipeline, DATA_W wide, with rdy/ack handshakes on both sides. It adds a sideband tag carried alongside each result, a synchronous flush, and an occupancy count. It sits between the ID and MEM/WB stages of the riscv core.

Parameters:
DATA_W, 32, operand/result width; must be a power of 2, minimum 8.
STAGES, 2, number of register stages from accept to output; legal range 1..4.
TAG_W, 5, width of sideband tag (e.g. rd index) carried with each op.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous flush; discards all in-flight ops
id_ex_rdy  in  1  upstream valid
id_ex_ack  out  1  pipe can accept this cycle
id_ex_funct  in  `EX_FUNCT_W  operation code (riscv_functions.vh encodings)
id_ex_op1  in  DATA_W  operand 1
id_ex_op2  in  DATA_W  operand 2
id_ex_tag  in  TAG_W  sideband tag
mem_wb_rdy  out  1  result valid
mem_wb_ack  in  1  downstream accept
mem_wb_data  out  DATA_W  result
mem_wb_tag  out  TAG_W  tag of result
occupancy  out  clog2(STAGES+1)  number of valid stages

Behaviour:
- Reset (async, rst=1): all stage valid bits clear. mem_wb_rdy=0, mem_wb_data=0, mem_wb_tag=0, occupancy=0. id_ex_ack=1 is allowed as soon as rst deasserts. Reset mid-operation drops every in-flight op with no output.
- Transfer rule: an input transfer occurs on an edge where id_ex_rdy && id_ex_ack. An output transfer occurs on an edge where mem_wb_rdy && mem_wb_ack. mem_wb_rdy, mem_wb_data and mem_wb_tag stay stable until the output transfer.
- ALU, evaluated combinationally on inputs and registered into stage 0:
  - ADD: op1+op2, mod 2^DATA_W.
  - SUB: op1-op2, mod 2^DATA_W.
  - OR, XOR, AND: bitwise.
  - STL: signed op1<op2, giving 1 or 0 zero-extended.
  - STLU: the unsigned equivalent.
  - SLL, SRL, SRA: shift op1 by op2[clog2(DATA_W)-1:0]; upper op2 bits are ignored. SRA sign-fills.
  - EX_NOP and any unlisted code: result 0, which still occupies a slot and still produces an output.
- Stages 1..STAGES-1 carry data and tag unchanged. The last stage drives mem_wb_*.
- Stage ready: stage i may load when its valid bit is 0, or when stage i+1 is ready (for the last stage, when mem_wb_ack=1). This collapses bubbles. id_ex_ack = stage-0 ready, combinational from mem_wb_ack through the ready chain. There is no path from id_ex_rdy to id_ex_ack.
- Latency: an op accepted on edge E appears on mem_wb_rdy after edge E+STAGES-1, i.e. exactly STAGES edges including E, provided there are no stalls.
- Throughput: 1 op/cycle while mem_wb_ack is held at 1.
- Full: with all STAGES valid and mem_wb_ack=0, id_ex_ack=0 and nothing moves.
- Simultaneous accept and output transfer while full: allowed. occupancy stays at STAGES.
- occupancy: registered count of valid bits; +1 on input transfer, -1 on output transfer, unchanged when both occur.
- Flush, when flush=1 at an edge:
  - All valid bits clear, any input transfer on that edge is discarded, and occupancy becomes 0.
  - The output transfer on that edge still counts as consumed by downstream.
  - id_ex_ack is not gated by flush.
- Order: results exit strictly in acceptance order. No reordering and no duplication.
- The data/tag registers of invalid stages may hold stale values. mem_wb_data is don't-care when mem_wb_rdy=0, except after reset, when it is 0.

Test Plan:
- STAGES=2, ack held 1: ADD 0x7FFFFFFF+0x00000001 at edge E -> mem_wb_rdy after edge E+1, data 0x80000000, tag echoed. Back-to-back SUB 0x0-0x1 gives 0xFFFFFFFF on the next cycle.
- Shifts and compares: SRA 0x80000000 by op2=0x00000021 -> 0xC0000000 (shift 1). SRL with the same operands -> 0x40000000. STL 0xFFFFFFFF<0x1 -> 1. STLU with the same operands -> 0. NOP -> 0.
- Backpressure, STAGES=3: hold mem_wb_ack=0 and push 4 ops -> id_ex_ack drops after the 3rd accept, occupancy=3, output stable. Release ack -> 4 results in order, one per cycle.
- Bubble collapse: STAGES=3, one op in the last stage, mem_wb_ack=0 -> stages 0..1 still accept 2 more ops. occupancy reaches 3.
- Flush, STAGES=2, full: assert flush together with id_ex_rdy=1 -> next cycle mem_wb_rdy=0 and occupancy=0. The flushed and simultaneous ops never appear.
- Async reset mid-stream: raise rst between edges with 2 ops in flight -> mem_wb_rdy=0 and occupancy=0 immediately. After release, a new ADD 2+3 -> 5 with correct latency.

Source files
------------

// File: rtl/riscv_ex_pipe_stg.sv
// Elastic STAGES-deep integer execute pipe between ID and MEM/WB.
// Carries a sideband tag, supports synchronous flush and tracks occupancy.
`ifndef EX_FUNCT_W
`define EX_FUNCT_W 4
`endif

module riscv_ex_pipe_stg #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          id_ex_rdy,
  output logic                          id_ex_ack,
  input  logic [`EX_FUNCT_W-1:0]        id_ex_funct,
  input  logic [DATA_W-1:0]             id_ex_op1,
  input  logic [DATA_W-1:0]             id_ex_op2,
  input  logic [TAG_W-1:0]              id_ex_tag,
  output logic                          mem_wb_rdy,
  input  logic                          mem_wb_ack,
  output logic [DATA_W-1:0]             mem_wb_data,
  output logic [TAG_W-1:0]              mem_wb_tag,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int FW  = `EX_FUNCT_W;
  localparam int SHW = $clog2(DATA_W);
  localparam int OW  = $clog2(STAGES+1);

  localparam logic [FW-1:0] EX_NOP  = FW'(0);
  localparam logic [FW-1:0] EX_ADD  = FW'(1);
  localparam logic [FW-1:0] EX_SUB  = FW'(2);
  localparam logic [FW-1:0] EX_OR   = FW'(3);
  localparam logic [FW-1:0] EX_XOR  = FW'(4);
  localparam logic [FW-1:0] EX_AND  = FW'(5);
  localparam logic [FW-1:0] EX_STL  = FW'(6);
  localparam logic [FW-1:0] EX_STLU = FW'(7);
  localparam logic [FW-1:0] EX_SLL  = FW'(8);
  localparam logic [FW-1:0] EX_SRL  = FW'(9);
  localparam logic [FW-1:0] EX_SRA  = FW'(10);

  logic              v_q   [STAGES];
  logic              v_d   [STAGES];
  logic [DATA_W-1:0] d_q   [STAGES];
  logic [TAG_W-1:0]  t_q   [STAGES];
  logic              src_v [STAGES];
  logic [DATA_W-1:0] src_d [STAGES];
  logic [TAG_W-1:0]  src_t [STAGES];
  logic              rdy   [STAGES+1];
  logic [OW-1:0]     occ_q, occ_d;
  logic [DATA_W-1:0] alu;
  logic [SHW-1:0]    shamt;
  logic              in_x, out_x;

  assign shamt = id_ex_op2[SHW-1:0];

  always_comb begin
    alu = '0;
    case (id_ex_funct)
      EX_ADD:  alu = id_ex_op1 + id_ex_op2;
      EX_SUB:  alu = id_ex_op1 - id_ex_op2;
      EX_OR:   alu = id_ex_op1 | id_ex_op2;
      EX_XOR:  alu = id_ex_op1 ^ id_ex_op2;
      EX_AND:  alu = id_ex_op1 & id_ex_op2;
      EX_STL:  alu = DATA_W'($signed(id_ex_op1) < $signed(id_ex_op2));
      EX_STLU: alu = DATA_W'(id_ex_op1 < id_ex_op2);
      EX_SLL:  alu = id_ex_op1 << shamt;
      EX_SRL:  alu = id_ex_op1 >> shamt;
      EX_SRA:  alu = DATA_W'($signed(id_ex_op1) >>> shamt);
      EX_NOP:  alu = '0;
      default: alu = '0;
    endcase
  end

  // Ready ripples back from downstream ack; an empty stage breaks the stall.
  always_comb begin
    rdy[STAGES] = mem_wb_ack;
    for (int i = STAGES-1; i >= 0; i--) begin
      rdy[i] = !v_q[i] || rdy[i+1];
    end
  end

  always_comb begin
    src_v[0] = id_ex_rdy;
    src_d[0] = alu;
    src_t[0] = id_ex_tag;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
      src_t[i] = t_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = flush ? 1'b0 : (rdy[i] ? src_v[i] : v_q[i]);
    end
  end

  assign in_x  = id_ex_rdy && rdy[0];
  assign out_x = v_q[STAGES-1] && mem_wb_ack;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      unique case ({in_x, out_x})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
        t_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= v_d[i];
        if (rdy[i]) begin
          d_q[i] <= src_d[i];
          t_q[i] <= src_t[i];
        end
      end
      occ_q <= occ_d;
    end
  end

  assign id_ex_ack   = rdy[0];
  assign mem_wb_rdy  = v_q[STAGES-1];
  assign mem_wb_data = d_q[STAGES-1];
  assign mem_wb_tag  = t_q[STAGES-1];
  assign occupancy   = occ_q;

endmodule
